// File: rtl/elevator_scan_ctrl.sv
// N-floor SCAN elevator controller: latches requests under grant, drives motor power and door.
// Optional macro ESTOP_EN adds an estop input that halts the motor and freezes the controller.
module elevator_scan_ctrl #(
    parameter int unsigned FLOORS      = 8,
    parameter int unsigned DOOR_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
`ifdef ESTOP_EN
    input  logic                      estop,
`endif
    input  logic                      grant,
    input  logic [FLOORS-1:0]         car_req,
    input  logic [FLOORS-1:0]         hall_req,
    input  logic [FLOORS-1:0]         floor_sns,
    output logic [1:0]                power,
    output logic                      door,
    output logic [$clog2(FLOORS)-1:0] cur_floor,
    output logic                      dir_up,
    output logic [FLOORS-1:0]         pending
);
    localparam int unsigned FW = $clog2(FLOORS);
    localparam int unsigned TW = $clog2(DOOR_CYCLES + 1);

    localparam logic [1:0]    PwrStop   = 2'b00;
    localparam logic [1:0]    PwrUp     = 2'b10;
    localparam logic [1:0]    PwrDown   = 2'b11;
    localparam logic [TW-1:0] DwellLoad = TW'(DOOR_CYCLES);
    localparam logic [FW-1:0] TopFloor  = FW'(FLOORS - 1);

    typedef enum logic [1:0] {StIdle, StDwell, StMoveUp, StMoveDown} state_e;

    state_e            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [1:0]        power_q, power_d;
    logic              door_q, door_d;
    logic              dir_up_q, dir_up_d;
    logic [FW-1:0]     cur_floor_q, cur_floor_d;
    logic [FLOORS-1:0] pending_q, pending_d;

    logic [FLOORS-1:0] req_in;
    logic              any_above, any_below;
    logic              sns_valid;
    logic [FW-1:0]     sns_idx;
    logic              start_move, go_up;

    always_comb begin : scan
        any_above = 1'b0;
        any_below = 1'b0;
        sns_idx   = '0;
        for (int i = 0; i < int'(FLOORS); i++) begin
            if (pending_q[i] && (FW'(i) > cur_floor_q)) any_above = 1'b1;
            if (pending_q[i] && (FW'(i) < cur_floor_q)) any_below = 1'b1;
            if (floor_sns[i]) sns_idx = FW'(i);
        end
        sns_valid = $onehot(floor_sns);
    end

    always_comb begin : next_state
        req_in      = grant ? (car_req | hall_req) : '0;
        state_d     = state_q;
        timer_d     = timer_q;
        power_d     = PwrStop;
        door_d      = door_q;
        dir_up_d    = dir_up_q;
        cur_floor_d = cur_floor_q;
        pending_d   = pending_q | req_in;
        start_move  = 1'b0;
        go_up       = dir_up_q;

        unique case (state_q)
            StIdle: begin
                door_d = 1'b1;
                if (pending_q[cur_floor_q]) begin
                    pending_d[cur_floor_q] = 1'b0;
                    timer_d                = DwellLoad;
                    state_d                = StDwell;
                end else if (dir_up_q ? any_above : any_below) begin
                    start_move = 1'b1;
                end else if (dir_up_q ? any_below : any_above) begin
                    start_move = 1'b1;
                    go_up      = ~dir_up_q;
                    dir_up_d   = ~dir_up_q;
                end
            end
            StDwell: begin
                // A press for the open floor extends the dwell instead of being queued.
                door_d                 = 1'b1;
                pending_d[cur_floor_q] = 1'b0;
                if (req_in[cur_floor_q]) begin
                    timer_d = DwellLoad;
                end else if (timer_q <= TW'(1)) begin
                    timer_d = '0;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            StMoveUp, StMoveDown: begin
                door_d  = 1'b0;
                power_d = (state_q == StMoveUp) ? PwrUp : PwrDown;
                if (sns_valid) begin
                    cur_floor_d = sns_idx;
                    if (pending_q[sns_idx] || req_in[sns_idx]) begin
                        pending_d[sns_idx] = 1'b0;
                        power_d            = PwrStop;
                        door_d             = 1'b1;
                        timer_d            = DwellLoad;
                        state_d            = StDwell;
                    end else if (((state_q == StMoveUp) && (sns_idx == TopFloor)) ||
                                 ((state_q == StMoveDown) && (sns_idx == '0))) begin
                        power_d = PwrStop;
                        door_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: ;
        endcase

        if (start_move) begin
            door_d  = 1'b0;
            state_d = go_up ? StMoveUp : StMoveDown;
            power_d = go_up ? PwrUp : PwrDown;
        end

`ifdef ESTOP_EN
        // Halt the motor but keep collecting requests; motion resumes from the frozen state.
        if (estop) begin
            state_d     = state_q;
            timer_d     = timer_q;
            door_d      = door_q;
            dir_up_d    = dir_up_q;
            cur_floor_d = cur_floor_q;
            power_d     = PwrStop;
            pending_d   = pending_q | req_in;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            power_q     <= PwrStop;
            door_q      <= 1'b1;
            dir_up_q    <= 1'b1;
            cur_floor_q <= '0;
            pending_q   <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            power_q     <= power_d;
            door_q      <= door_d;
            dir_up_q    <= dir_up_d;
            cur_floor_q <= cur_floor_d;
            pending_q   <= pending_d;
        end
    end

    assign power     = power_q;
    assign door      = door_q;
    assign cur_floor = cur_floor_q;
    assign dir_up    = dir_up_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Bench for elevator_scan_ctrl: request-level model checked every cycle, a simple shaft plant
// that turns motor power into floor sensor pulses, and directed scenarios with literal checks.
module tb_elevator_scan_ctrl;
    localparam int F     = 8;
    localparam int DC    = 16;
    localparam int MIdle = 0;
    localparam int MDwell = 1;
    localparam int MMove = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         grant = 1'b0;
    logic         estop = 1'b0;
    logic [F-1:0] car_req = '0;
    logic [F-1:0] hall_req = '0;
    logic [F-1:0] floor_sns = '0;
    logic [1:0]   power;
    logic         door;
    logic [2:0]   cur_floor;
    logic         dir_up;
    logic [F-1:0] pending;

    int n_checks = 0;
    int n_err = 0;

    // Model: mode, floor, direction, request set, remaining dwell cycles, motor halted.
    int           m_mode = MIdle;
    int           m_floor = 0;
    int           m_left = 0;
    bit           m_dir = 1'b1;
    bit           m_halt = 1'b0;
    logic [F-1:0] m_pend = '0;

    int           pos = 0;
    int           cnt = 0;
    int           n_stops = 0;
    bit           prev_door = 1'b1;
    bit           force_on = 1'b0;
    logic [F-1:0] force_val = '0;

    elevator_scan_ctrl #(.FLOORS(F), .DOOR_CYCLES(DC)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef ESTOP_EN
        .estop     (estop),
`endif
        .grant     (grant),
        .car_req   (car_req),
        .hall_req  (hall_req),
        .floor_sns (floor_sns),
        .power     (power),
        .door      (door),
        .cur_floor (cur_floor),
        .dir_up    (dir_up),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [F-1:0] req;
        logic [F-1:0] p_old;
        bit           above;
        bit           below;
        int           f;
        req    = grant ? (car_req | hall_req) : '0;
        p_old  = m_pend;
        m_pend = p_old | req;
        m_halt = estop;
        if (estop) return;
        if (m_mode == MIdle) begin
            above = 1'b0;
            below = 1'b0;
            for (int i = 0; i < F; i++) begin
                if (p_old[i] && i > m_floor) above = 1'b1;
                if (p_old[i] && i < m_floor) below = 1'b1;
            end
            if (p_old[m_floor]) begin
                m_pend[m_floor] = 1'b0;
                m_mode = MDwell;
                m_left = DC;
            end else if (m_dir ? above : below) begin
                m_mode = MMove;
            end else if (m_dir ? below : above) begin
                m_dir  = !m_dir;
                m_mode = MMove;
            end
        end else if (m_mode == MDwell) begin
            m_pend[m_floor] = 1'b0;
            if (req[m_floor]) m_left = DC;
            else begin
                m_left--;
                if (m_left == 0) m_mode = MIdle;
            end
        end else if ($onehot(floor_sns)) begin
            f = 0;
            for (int i = 0; i < F; i++) if (floor_sns[i]) f = i;
            m_floor = f;
            if (m_pend[f]) begin
                m_pend[f] = 1'b0;
                m_mode = MDwell;
                m_left = DC;
            end else if ((m_dir && f == F - 1) || (!m_dir && f == 0)) begin
                m_mode = MIdle;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_mode = MIdle;
            m_floor = 0;
            m_left = 0;
            m_dir = 1'b1;
            m_halt = 1'b0;
            m_pend = '0;
        end else begin
            model_step();
        end
    end

    // Compare against the model, then advance the shaft plant (3 cycles per floor).
    initial forever begin
        @(negedge clk);
        if (rst) begin
            pos = 0;
            cnt = 0;
            prev_door = 1'b1;
            floor_sns = '0;
        end else begin
            chk("cmp_power", power,
                (m_mode == MMove && !m_halt) ? (m_dir ? 2'b10 : 2'b11) : 2'b00);
            chk("cmp_door", door, m_mode != MMove);
            chk("cmp_floor", cur_floor, m_floor);
            chk("cmp_dir", dir_up, m_dir);
            chk("cmp_pending", pending, m_pend);
            if (door && !prev_door) n_stops++;
            prev_door = door;
            floor_sns = '0;
            if (power == 2'b00) cnt = 0;
            else begin
                cnt++;
                if (cnt == 3) begin
                    cnt = 0;
                    if (power == 2'b10 && pos < F - 1) pos++;
                    else if (power == 2'b11 && pos > 0) pos--;
                    floor_sns[pos] = 1'b1;
                end
            end
            if (force_on) floor_sns = force_val;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_arrive(input int f, input int max, input string name);
        int         n;
        logic [2:0] ff;
        n  = 0;
        ff = 3'(f);
        while (!(door === 1'b1 && power === 2'b00 && cur_floor === ff) && n < max) begin
            step();
            n++;
        end
        chk(name, {door, power, cur_floor}, {1'b1, 2'b00, ff});
    endtask

    task automatic wait_power(input logic [1:0] p, input int max, input string name);
        int n;
        n = 0;
        while (power !== p && n < max) begin
            step();
            n++;
        end
        chk(name, power, p);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

    initial begin
        int n;
        int s0;
        #1 rst = 1'b1;
        #1;
        chk("rst_power", power, 2'b00);
        chk("rst_door", door, 1'b1);
        chk("rst_floor", cur_floor, 0);
        chk("rst_dir", dir_up, 1'b1);
        chk("rst_pending", pending, 0);
        step();
        rst = 1'b0;

        // grant low: requests ignored
        grant = 1'b0;
        hall_req = 8'hFF;
        repeat (3) step();
        chk("nogrant_pending", pending, 0);
        chk("nogrant_power", power, 2'b00);
        chk("nogrant_door", door, 1'b1);
        hall_req = '0;
        grant = 1'b1;

        // single request for floor 5: two-cycle latency, stop at 5
        car_req[5] = 1'b1;
        step();
        car_req = '0;
        chk("lat1_power", power, 2'b00);
        chk("lat1_pending", pending, 8'h20);
        step();
        chk("lat2_power", power, 2'b10);
        chk("lat2_door", door, 1'b0);
        wait_arrive(5, 80, "arrive5");
        chk("arrive5_pend", pending[5], 1'b0);
        chk("model_floor5", m_floor, 5);

        // dwell at 5: queue floor 0, then re-press floor 5 at count 2
        hall_req[0] = 1'b1;
        step();
        hall_req = '0;
        step();
        car_req[5] = 1'b1;
        step();
        car_req = '0;
        chk("dwell_no_latch", pending[5], 1'b0);
        n = 3;
        while (power === 2'b00 && n < 60) begin
            n++;
            step();
        end
        chk("dwell_reload_len", n, 20);
        chk("dwell_reload_dir", dir_up, 1'b0);

        // plain dwell at floor 0
        wait_arrive(0, 80, "arrive0");
        car_req[3] = 1'b1;
        step();
        car_req = '0;
        n = 1;
        while (power === 2'b00 && n < 60) begin
            n++;
            step();
        end
        chk("dwell_len", n, 17);
        chk("dwell_dir_flip", dir_up, 1'b1);

        // at 3 going up with requests {1,6}: 6 first, then 1 with no stops between
        wait_arrive(3, 80, "arrive3");
        car_req[1] = 1'b1;
        hall_req[6] = 1'b1;
        step();
        car_req = '0;
        hall_req = '0;
        wait_arrive(6, 80, "scan_first6");
        chk("scan6_dir", dir_up, 1'b1);
        chk("scan6_pending", pending, 8'h02);
        chk("model_floor6", m_floor, 6);
        s0 = n_stops;
        wait_arrive(1, 80, "scan_then1");
        chk("scan1_dir", dir_up, 1'b0);
        chk("scan1_pending", pending, 0);
        chk("scan1_no_extra_stops", n_stops - s0, 1);

        // multi-hot sensor holds floor; bogus top-floor hit while going up stops at limit
        car_req[4] = 1'b1;
        step();
        car_req = '0;
        wait_power(2'b10, 40, "depart1");
        force_on = 1'b1;
        force_val = 8'h18;
        step();
        force_val = 8'h80;
        step();
        force_on = 1'b0;
        chk("multihot_hold", cur_floor, 1);
        step();
        chk("limit_power", power, 2'b00);
        chk("limit_door", door, 1'b1);
        chk("limit_floor", cur_floor, 7);
        wait_arrive(4, 120, "arrive4");

        // async reset while moving up
        car_req[7] = 1'b1;
        step();
        car_req = '0;
        wait_power(2'b10, 40, "depart4");
        step();
        step();
        rst = 1'b1;
        #1;
        chk("midrst_power", power, 2'b00);
        chk("midrst_door", door, 1'b1);
        chk("midrst_floor", cur_floor, 0);
        chk("midrst_pending", pending, 0);
        chk("midrst_dir", dir_up, 1'b1);
        step();
        rst = 1'b0;
        step();

`ifdef ESTOP_EN
        car_req[5] = 1'b1;
        step();
        car_req = '0;
        wait_power(2'b10, 10, "estop_depart");
        step();
        estop = 1'b1;
        step();
        chk("estop_power", power, 2'b00);
        chk("estop_door", door, 1'b0);
        car_req[2] = 1'b1;
        step();
        car_req = '0;
        step();
        step();
        chk("estop_latch", pending, 8'h24);
        estop = 1'b0;
        step();
        chk("estop_resume", power, 2'b10);
        wait_arrive(2, 60, "estop_arrive2");
        wait_arrive(5, 80, "estop_arrive5");
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
